// File: rtl/cac_fns_pkg.sv
// Shared definitions for the Fibonacci numeral system (FNS)
// crosstalk-avoidance codec family.
package cac_fns_pkg;

   localparam int N_TSV_MIN = 3;
   localparam int N_TSV_MAX = 24;

   typedef enum logic [1:0] {
      IDLE,
      ENC,
      DONE
   } cac_enc_state_t;

   // Fibonacci number with fib(0)=0, fib(1)=1.
   function automatic int fib(input int n);
      int a;
      int b;
      int t;
      a = 0;
      b = 1;
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Largest value representable with n_tsv FNS digits.
   function automatic int fns_max(input int n_tsv);
      return fib(n_tsv + 2) - 1;
   endfunction

endpackage

// File: rtl/fns_digit_stage.sv
// One greedy FNS digit: compare the remainder
// against a weight and subtract on a hit.
module fns_digit_stage #(
   parameter int W = 4
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] weight,
   output logic         digit,
   output logic [W-1:0] next_rem
);

   assign digit    = (rem >= weight);
   assign next_rem = digit ? (rem - weight) : rem;

endmodule

// File: rtl/cac_fns_seq_encoder.sv
// Multi-cycle FNS crosstalk-avoidance encoder.
// Emits one Zeckendorf digit per clock, MSB first.
module cac_fns_seq_encoder
   import cac_fns_pkg::*;
#(
   parameter int N_TSV  = 5,
   parameter int DATA_W = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [N_TSV-1:0]  out_code,
   output logic              out_err,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   localparam int KW = (N_TSV > 1) ? $clog2(N_TSV) : 1;
   localparam int KN = 1 << KW;
   localparam logic [DATA_W-1:0] MAXV = DATA_W'(fns_max(N_TSV));
   localparam logic [KW-1:0] K_TOP = KW'(N_TSV - 1);

   if (N_TSV < N_TSV_MIN || N_TSV > N_TSV_MAX) begin : g_bad_n
      $error("cac_fns_seq_encoder: N_TSV out of range");
   end
   if ((longint'(1) << DATA_W) < longint'(fib(N_TSV + 2))) begin : g_bad_w
      $error("cac_fns_seq_encoder: DATA_W too narrow");
   end

   cac_enc_state_t state, state_nxt;
   logic [DATA_W-1:0] rem, rem_nxt;
   logic [KW-1:0]     k, k_nxt;
   logic [N_TSV-1:0]  code, code_nxt, code_ins;
   logic [N_TSV-1:0]  oc_nxt;
   logic              oe_nxt, ov_nxt;
   logic [DATA_W-1:0] weight, next_rem;
   logic              digit;
   logic [DATA_W-1:0] wtab [KN];

   for (genvar i = 0; i < KN; i++) begin : g_w
      assign wtab[i] = (i < N_TSV) ? DATA_W'(fib(i + 2)) : '0;
   end

   assign weight = wtab[k];

   fns_digit_stage #(.W(DATA_W)) u_digit (
      .rem      (rem),
      .weight   (weight),
      .digit    (digit),
      .next_rem (next_rem)
   );

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // Merge the current digit into bit k of the code.
   always_comb begin
      code_ins = code;
      for (int i = 0; i < N_TSV; i++) begin
         if (k == KW'(i)) code_ins[i] = digit;
      end
   end

   // Next-state and datapath update for the FSM.
   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      k_nxt     = k;
      code_nxt  = code;
      oc_nxt    = out_code;
      oe_nxt    = out_err;
      ov_nxt    = out_valid;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               if (in_data <= MAXV) begin
                  rem_nxt   = in_data;
                  k_nxt     = K_TOP;
                  code_nxt  = '0;
                  state_nxt = ENC;
               end else begin
                  oc_nxt    = '0;
                  oe_nxt    = 1'b1;
                  ov_nxt    = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         ENC: begin
            rem_nxt  = next_rem;
            code_nxt = code_ins;
            k_nxt    = k - KW'(1);
            if (k == '0) begin
               k_nxt     = '0;
               oc_nxt    = code_ins;
               oe_nxt    = 1'b0;
               ov_nxt    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               ov_nxt    = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         rem       <= '0;
         k         <= '0;
         code      <= '0;
         out_code  <= '0;
         out_err   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         rem       <= rem_nxt;
         k         <= k_nxt;
         code      <= code_nxt;
         out_code  <= oc_nxt;
         out_err   <= oe_nxt;
         out_valid <= ov_nxt;
      end
   end

   a_no_adj: assert property (@(posedge clock) disable iff (!reset_n)
      out_valid |-> ((out_code & (out_code >> 1)) == '0));

   a_rem_zero: assert property (@(posedge clock) disable iff (!reset_n)
      (state == ENC && k == '0) |-> (next_rem == '0));

   a_greedy: assert property (@(posedge clock) disable iff (!reset_n)
      (state == ENC && k != '0 && digit) |->
      (next_rem < wtab[k - KW'(1)]));

endmodule

// File: tb/tb_cac_fns_seq_encoder.sv
// Scoreboard bench for cac_fns_seq_encoder,
// N_TSV=5 and N_TSV=8 instances.
module tb_cac_fns_seq_encoder;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset_n;
   logic [3:0] in_data5;
   logic in_valid5, in_ready5, out_err5, out_valid5, out_ready5, busy5;
   logic [4:0] out_code5;
   logic [5:0] in_data8;
   logic in_valid8, in_ready8, out_err8, out_valid8, out_ready8, busy8;
   logic [7:0] out_code8;

   cac_fns_seq_encoder #(.N_TSV(5), .DATA_W(4)) dut5 (
      .clock(clock), .reset_n(reset_n),
      .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
      .out_code(out_code5), .out_err(out_err5), .out_valid(out_valid5),
      .out_ready(out_ready5), .busy(busy5));

   cac_fns_seq_encoder #(.N_TSV(8), .DATA_W(6)) dut8 (
      .clock(clock), .reset_n(reset_n),
      .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
      .out_code(out_code8), .out_err(out_err8), .out_valid(out_valid8),
      .out_ready(out_ready8), .busy(busy8));

   typedef struct {
      int         val;
      logic       err;
      logic       cc;
      logic [7:0] code;
      int         acc;
   } exp_t;

   exp_t q5[$];
   exp_t q8[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit rnd = 0;
   logic pv5, pv8;

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      #1;
      if (rnd) begin
         out_ready5 = 1'($urandom_range(0, 1));
         out_ready8 = 1'($urandom_range(0, 1));
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int decode(input logic [7:0] c);
      int a, b, t, s;
      a = 1; b = 2; s = 0;
      for (int i = 0; i < 8; i++) begin
         if (c[i]) s += a;
         t = a + b; a = b; b = t;
      end
      return s;
   endfunction

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: output with empty scoreboard", name);
   endtask

   // Monitor for the N_TSV=5 instance.
   always @(negedge clock) begin
      exp_t e;
      if (!reset_n) pv5 <= 1'b0;
      else begin
         if (out_valid5 && !pv5) begin
            if (q5.size() == 0) unexpected("valid5");
            else chk("latency5", cyc - q5[0].acc, q5[0].err ? 0 : 5);
         end
         if (out_valid5 && out_ready5) begin
            if (q5.size() == 0) unexpected("pop5");
            else begin
               e = q5.pop_front();
               chk("err5", out_err5, e.err);
               if (!e.err) chk("decode5", decode(8'(out_code5)), e.val);
               chk("adj5", 32'(out_code5 & (out_code5 >> 1)), 0);
               if (e.cc) chk("code5", out_code5, e.code);
            end
         end
         pv5 <= out_valid5;
      end
   end

   // Monitor for the N_TSV=8 instance.
   always @(negedge clock) begin
      exp_t e;
      if (!reset_n) pv8 <= 1'b0;
      else begin
         if (out_valid8 && !pv8) begin
            if (q8.size() == 0) unexpected("valid8");
            else chk("latency8", cyc - q8[0].acc, q8[0].err ? 0 : 8);
         end
         if (out_valid8 && out_ready8) begin
            if (q8.size() == 0) unexpected("pop8");
            else begin
               e = q8.pop_front();
               chk("err8", out_err8, e.err);
               if (!e.err) chk("decode8", decode(out_code8), e.val);
               chk("adj8", 32'(out_code8 & (out_code8 >> 1)), 0);
            end
         end
         pv8 <= out_valid8;
      end
   end

   task automatic send5(input int v, input logic err, input logic cc,
                        input logic [7:0] code, input bit push);
      int n = 0;
      @(negedge clock);
      while (!in_ready5 && n < 300) begin @(negedge clock); n++; end
      if (!in_ready5) begin unexpected("send5_timeout"); return; end
      in_data5 = 4'(v);
      in_valid5 = 1'b1;
      @(posedge clock);
      #1;
      in_valid5 = 1'b0;
      if (push) q5.push_back('{v, err, cc, code, cyc});
   endtask

   task automatic send8(input int v);
      int n = 0;
      @(negedge clock);
      while (!in_ready8 && n < 300) begin @(negedge clock); n++; end
      if (!in_ready8) begin unexpected("send8_timeout"); return; end
      in_data8 = 6'(v);
      in_valid8 = 1'b1;
      @(posedge clock);
      #1;
      in_valid8 = 1'b0;
      q8.push_back('{v, 1'b0, 1'b0, 8'h00, cyc});
   endtask

   task automatic drain();
      int n = 0;
      while ((q5.size() != 0 || q8.size() != 0) && n < 5000) begin
         @(negedge clock);
         n++;
      end
      chk("drain_left", q5.size() + q8.size(), 0);
   endtask

   initial begin
      int n;
      reset_n = 1'b0;
      in_data5 = '0; in_valid5 = 1'b0; out_ready5 = 1'b1;
      in_data8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_code", out_code5, 0);
      chk("rst_err", out_err5, 0);
      chk("rst_valid", out_valid5, 0);
      chk("rst_busy", busy5, 0);
      chk("rst_in_ready", in_ready5, 1);
      reset_n = 1'b1;

      send5(12, 1'b0, 1'b1, 8'b10101, 1);
      send5(7, 1'b0, 1'b1, 8'b01010, 1);
      send5(0, 1'b0, 1'b1, 8'b00000, 1);
      send5(13, 1'b1, 1'b1, 8'b00000, 1);
      send5(12, 1'b0, 1'b1, 8'b10101, 1);
      send5(3, 1'b0, 1'b1, 8'b00100, 1);
      drain();

      @(posedge clock); #1;
      out_ready5 = 1'b0;
      send5(11, 1'b0, 1'b1, 8'b10100, 1);
      n = 0;
      while (!out_valid5 && n < 50) begin @(negedge clock); n++; end
      chk("stall_valid_seen", out_valid5, 1);
      repeat (10) begin
         @(negedge clock);
         chk("stall_code", out_code5, 5'b10100);
         chk("stall_in_ready", in_ready5, 0);
         chk("stall_valid", out_valid5, 1);
      end
      @(posedge clock); #1;
      out_ready5 = 1'b1;
      @(posedge clock); #1;
      chk("release_busy", busy5, 0);
      chk("release_in_ready", in_ready5, 1);
      chk("release_valid", out_valid5, 0);
      chk("release_code_kept", out_code5, 5'b10100);
      drain();

      send5(12, 1'b0, 1'b0, 8'h00, 0);
      @(posedge clock);
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_valid", out_valid5, 0);
      chk("abort_busy", busy5, 0);
      chk("abort_in_ready", in_ready5, 1);
      chk("abort_code", out_code5, 0);
      @(posedge clock); #2;
      reset_n = 1'b1;
      repeat (12) @(negedge clock);
      chk("abort_no_output", out_valid5, 0);

      rnd = 1;
      fork
         for (int v = 0; v <= 12; v++) send5(v, 1'b0, 1'b0, 8'h00, 1);
         for (int v = 0; v <= 54; v++) send8(v);
      join
      drain();
      rnd = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
